// File: rtl/multiword_adder_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_adder_sequencer_if
//  Description : Operand/result handshake bundle for multiword_adder_sequencer.
//                master : requester side (drives operands, takes results)
//                slave  : adder side
//                Signals: start_valid/start_ready, a, b, cin, [sub],
//                         res_valid/res_ready, sum, cout, busy.
//                The sub signal exists only when MWADD_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multiword_adder_sequencer_if #(
    parameter int N      = 4,
    parameter int SLICES = 4
);
    localparam int W = N * SLICES;

    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
`ifdef MWADD_SUB_EN
    logic           sub;
`endif
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           busy;

`ifdef MWADD_SUB_EN
    modport master (
        output start_valid, a, b, cin, sub, res_ready,
        input  start_ready, res_valid, sum, cout, busy
    );
    modport slave (
        input  start_valid, a, b, cin, sub, res_ready,
        output start_ready, res_valid, sum, cout, busy
    );
`else
    modport master (
        output start_valid, a, b, cin, res_ready,
        input  start_ready, res_valid, sum, cout, busy
    );
    modport slave (
        input  start_valid, a, b, cin, res_ready,
        output start_ready, res_valid, sum, cout, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/multiword_adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_adder_sequencer
//  Description : W = N*SLICES bit adder that reuses one N-bit ripple chain
//                over SLICES cycles, carrying between slices in a register.
//                Optional macro MWADD_SUB_EN adds a subtract request (sub):
//                b is inverted and the carry-in forced to 1 (a - b).
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                bus.slave - operand/result handshake (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module multiword_adder_sequencer #(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    multiword_adder_sequencer_if.slave  bus
);
    localparam int W       = N * SLICES;
    localparam int c_idx_w = $clog2(SLICES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;          // b already in effective form
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic [W-1:0]         r_sum;
    logic                 r_cout;

    logic                 w_accept;
    logic                 w_last;
    logic [W-1:0]         w_b_eff;
    logic                 w_cin_eff;
    logic [N:0]           w_slice;

    // Subtraction is folded in at acceptance, so the ripple chain only adds.
`ifdef MWADD_SUB_EN
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    assign w_accept = (r_state == IDLE) && bus.start_valid;
    assign w_last   = (r_idx == c_last_idx);

    // The single shared N-bit ripple chain.
    assign w_slice = {1'b0, r_a[r_idx*N +: N]}
                   + {1'b0, r_b[r_idx*N +: N]}
                   + {{N{1'b0}}, r_carry};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_valid) w_state_next = RUN;
            RUN:     if (w_last)          w_state_next = DONE;
            DONE:    if (bus.res_ready)   w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= w_b_eff;
                r_idx   <= '0;
                r_carry <= w_cin_eff;
                r_sum   <= '0;
            end else if (r_state == RUN) begin
                r_sum[r_idx*N +: N] <= w_slice[N-1:0];
                r_carry             <= w_slice[N];
                r_idx               <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_slice[N];
                end
            end
        end
    end

    // Handshake outputs are decoded from state only: no input-to-output path.
    assign bus.start_ready = (r_state == IDLE);
    assign bus.res_valid   = (r_state == DONE);
    assign bus.busy        = (r_state == RUN) || (r_state == DONE);
    assign bus.sum         = r_sum;
    assign bus.cout        = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_multiword_adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiword_adder_sequencer
//  Description : Directed self-checking bench for multiword_adder_sequencer,
//                N=4, SLICES=4 (W=16). Subtract vectors run when
//                MWADD_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiword_adder_sequencer;
    localparam int N      = 4;
    localparam int SLICES = 4;
    localparam int W      = N * SLICES;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multiword_adder_sequencer_if #(.N(N), .SLICES(SLICES)) bus ();

    multiword_adder_sequencer #(.N(N), .SLICES(SLICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef MWADD_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub request ignored in this build");
`endif
    endtask

    // Presents an operation at a negedge, scrambles the operands after the
    // acceptance edge, checks the slice-by-slice progress and the 4-cycle
    // latency. Returns at the negedge where DONE is first visible.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic rr,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        logic [W-1:0] mask;
        @(negedge clk);
        drive(a, b, cin, sub);
        bus.start_valid = 1'b1;
        bus.res_ready   = rr;
        check({tag, " start_ready idle"}, 32'(bus.start_ready), 32'd1);
        @(negedge clk);                              // E0 has passed
        bus.start_valid = 1'b0;
        drive(~a, ~b, ~cin, ~sub);
        check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
        check({tag, " sum cleared"}, 32'(bus.sum), 32'd0);
        for (int k = 1; k <= SLICES; k++) begin
            @(negedge clk);                          // E_k has passed
            mask = W'((32'd1 << (k * N)) - 1);
            if (k < SLICES) begin
                check({tag, " res_valid early"}, 32'(bus.res_valid), 32'd0);
                check({tag, " partial sum"}, 32'(bus.sum), 32'(exp_sum & mask));
            end else begin
                check({tag, " res_valid"}, 32'(bus.res_valid), 32'd1);
                check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
                check({tag, " cout"}, 32'(bus.cout), 32'(exp_cout));
                check({tag, " start_ready in done"}, 32'(bus.start_ready), 32'd0);
            end
        end
    endtask

    // Releases the result and confirms a single-cycle res_valid.
    task automatic take_result(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check({tag, " res_valid drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, " back to idle"}, 32'(bus.start_ready), 32'd1);
        check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        drive('0, '0, 1'b0, 1'b0);

        // Asynchronous reset, asserted away from any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset start_ready", 32'(bus.start_ready), 32'd1);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset sum", 32'(bus.sum), 32'h0000);
        check("reset cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add with res_ready held high throughout.
        run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        take_result("basic");

        run_op("basic_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0);
        take_result("basic_cin");

        // Carry ripples through every slice.
        run_op("ripple_b", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        take_result("ripple_b");
        run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
        take_result("ripple_cin");

        // Backpressure: a new request waits while DONE is held.
        run_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0);
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        bus.start_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp hold valid", 32'(bus.res_valid), 32'd1);
            check("bp hold sum", 32'(bus.sum), 32'h3333);
            check("bp hold cout", 32'(bus.cout), 32'd0);
            check("bp start_ready low", 32'(bus.start_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);                              // back in IDLE, not yet taken
        check("bp idle", 32'(bus.start_ready), 32'd1);
        check("bp not queued", 32'(bus.busy), 32'd0);
        bus.res_ready = 1'b0;
        bus.start_valid = 1'b0;
        run_op("bp_next", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b0);
        take_result("bp_next");

        // Reset during RUN after two slices.
        run_op("pre_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        take_result("pre_abort");
        @(negedge clk);
        drive(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);                              // two slices done
        rst = 1'b1;
        #1;
        check("abort start_ready", 32'(bus.start_ready), 32'd1);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort sum", 32'(bus.sum), 32'h0000);
        check("abort res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < SLICES + 1; k++) begin
            @(negedge clk);
            check("abort no result", 32'(bus.res_valid), 32'd0);
        end
        run_op("post_abort", 16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        take_result("post_abort");

`ifdef MWADD_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        take_result("sub_borrow");
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1);
        take_result("sub_noborrow");
        run_op("sub0_add", 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h000D, 1'b0);
        take_result("sub0_add");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the directed sequence is ever broken.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multiword_adder_sequencer.md
# multiword_adder_sequencer

Multi-cycle wide adder that reuses one N-bit full-adder ripple chain over SLICES consecutive clock cycles to add two N*SLICES-bit operands. The block holds the carry between slices in a register and presents a valid/ready handshake on both the operand and result sides. It sits between a requesting datapath and the narrow ripple-carry resource, trading latency for area.

## Interface
- N, 4, slice width in bits; width of the single shared ripple chain; N >= 2.
- SLICES, 4, number of slices per operation; SLICES >= 2. Operand width W = N*SLICES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operand request.
- start_ready  out  1  block can accept operands.
- a  in  W  operand A; sampled at acceptance.
- b  in  W  operand B; sampled at acceptance.
- cin  in  1  carry into slice 0; sampled at acceptance.
- sub  in  1  subtract request; port present only with MWADD_SUB_EN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- sum  out  W  registered result.
- cout  out  1  registered carry out of the top slice.
- busy  out  1  high in RUN and DONE.

## Operation
- The block has three states: IDLE, RUN and DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready, capture a, b, cin (and sub) into operand registers.
  - Clear the slice index to 0, load the carry register with the effective carry-in, clear the sum register, then go to RUN.
- RUN:
  - Each cycle, one N-bit ripple chain adds a_reg[idx*N +: N] + b_eff[idx*N +: N] + carry_reg.
  - On the edge, sum[idx*N +: N] takes the slice sum, carry_reg takes the slice carry out, and idx increments.
  - When idx == SLICES-1 on the edge, also load cout with the slice carry, then go to DONE.
- DONE:
  - res_valid = 1.
  - On res_valid & res_ready, go to IDLE.
- start_ready is high only in IDLE. start_valid in RUN or DONE is ignored and does not queue.
- The sum register holds stable from entry to DONE until the next acceptance.
- sum bits update slice by slice during RUN. sum is meaningful only while res_valid is high.
- Arithmetic:
  - Result = (a + b_eff + carry_in) mod 2^W; cout is bit W of the full sum.
  - Unsigned wrap-around is silent. No overflow flag.
- Operands that change after acceptance have no effect on the current operation.

## Timing
- Reset values, applied asynchronously: state IDLE, idx 0, carry_reg 0, sum 0, cout 0, res_valid 0, busy 0, start_ready 1.
- Reset asserted in any state aborts the operation immediately. No partial result is ever flagged valid.
- Acceptance edge is E0.
- Slices 0..SLICES-1 are processed on edges E1..E_SLICES.
- res_valid rises in the cycle after E_SLICES, i.e. a latency of SLICES cycles from acceptance to result.
- With res_ready held high, res_valid lasts exactly 1 cycle and IDLE returns after E_SLICES+1.
- Minimum start-to-start period is SLICES+2 cycles.
- res_ready low holds DONE, sum and cout indefinitely.
- res_ready asserted outside DONE is ignored.
- start_ready and res_valid are decoded from state only. There is no combinational path from any input to any output.

## Configuration
- MWADD_SUB_EN defined:
  - sub port exists.
  - With sub=1 at acceptance, b_eff = ~b, the effective carry-in is 1 and cin is ignored, so the result is a - b mod 2^W.
  - cout = 1 means no borrow.
  - sub=0 behaves as plain addition.
- MWADD_SUB_EN undefined:
  - No sub port.
  - b_eff = b and the effective carry-in is cin.

## Test plan
All scenarios use N=4 and SLICES=4 (W=16).
- Reset: assert rst mid-cycle -> immediately start_ready=1, res_valid=0, busy=0, sum=0x0000, cout=0.
- Basic add: a=0x1234, b=0x4321, cin=0 -> res_valid exactly 4 cycles after acceptance, sum=0x5555, cout=0, res_valid 1 cycle with res_ready=1.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Backpressure: res_ready=0 for 3 cycles after res_valid, with start_valid=1 and new operands -> sum and cout are held, start_ready=0, the new request is not taken until IDLE, then completes correctly.
- Reset mid-RUN: assert rst after 2 slices -> IDLE, sum=0, res_valid never asserts for the aborted op. The next op a=0x00F0, b=0x0010 gives sum=0x0100.
- MWADD_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
